// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, pipeline sideband type and int8 saturation for conv_pe_quant
//
// Contents:
//   PIX_W, W_W, OUT_W       pixel, weight and result widths
//   LEAKY_MUL, LEAKY_SH     leaky ReLU slope as 13/128
//   conv_sb_t               per-beat sideband travelling beside the datapath
//   sat_int8()              clamp a wide signed value to [-128, 127]
package conv_pkg;

  localparam int PIX_W     = 8;
  localparam int W_W       = 8;
  localparam int OUT_W     = 8;
  localparam int LEAKY_MUL = 13;
  localparam int LEAKY_SH  = 7;

  // Bias and scale fields are sized for the widest supported instance;
  // each instance reads back only its own ACC_W / SCALE_W low bits.
  localparam int SB_BIAS_W  = 64;
  localparam int SB_SCALE_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic                  mode;
    logic [SB_BIAS_W-1:0]  bias;
    logic [SB_SCALE_W-1:0] scale;
    logic [4:0]            shift;
    logic                  leaky;
  } conv_sb_t;

  function automatic logic signed [OUT_W-1:0] sat_int8(input logic signed [63:0] v);
    if (v > 64'sd127)       return 8'sd127;
    else if (v < -64'sd128) return -8'sd128;
    else                    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - requantisation stages Q1 (scale multiply) and Q2 (round, shift, leaky, saturate)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               pipeline advance; all registers hold while low
//   valid_in         raw carries a completed pixel sum
//   raw              signed accumulated sum incl. bias
//   scale, shift     unsigned multiplier and rounding right-shift
//   leaky_en         apply leaky ReLU to negative results
//   out, out_valid   saturated int8 result and its valid
// Macro CONV_PE_LEAKY_EN compiles the leaky stage in; without it leaky_en is ignored.
module conv_requant
  import conv_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    valid_in,
  input  logic signed [ACC_W-1:0] raw,
  input  logic [SCALE_W-1:0]      scale,
  input  logic [4:0]              shift,
  input  logic                    leaky_en,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid
);

  localparam int P_W = ACC_W + SCALE_W + 1;
  // Q2 arithmetic runs at 64 bits so the leaky multiply cannot overflow.
  localparam int QW  = 64;

  logic signed [P_W-1:0] p_d, p_q;
  logic [4:0]            q1_shift;
  logic                  q1_valid;
  logic signed [QW-1:0]  v_round, v_shift, v_fin;

  // scale is unsigned: a zero sign bit keeps it positive in the signed multiply
  assign p_d = P_W'(raw) * P_W'($signed({1'b0, scale}));

`ifdef CONV_PE_LEAKY_EN
  logic q1_leaky;
`else
  logic unused_leaky;
  assign unused_leaky = leaky_en;
`endif

  always_comb begin
    v_round = QW'(p_q);
    if (q1_shift != 5'd0) v_round = v_round + (QW'(1) << (q1_shift - 5'd1));
    v_shift = v_round >>> q1_shift;
    v_fin   = v_shift;
`ifdef CONV_PE_LEAKY_EN
    if (q1_leaky && v_shift < 0)
      v_fin = (v_shift * QW'(LEAKY_MUL) + (QW'(1) << (LEAKY_SH - 1))) >>> LEAKY_SH;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      q1_shift  <= '0;
      q1_valid  <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef CONV_PE_LEAKY_EN
      q1_leaky  <= 1'b0;
`endif
    end else if (en) begin
      p_q       <= p_d;
      q1_shift  <= shift;
      q1_valid  <= valid_in;
      out_valid <= q1_valid;
      if (q1_valid) out <= sat_int8(v_fin);
`ifdef CONV_PE_LEAKY_EN
      q1_leaky  <= leaky_en;
`endif
    end
  end

endmodule

// File: rtl/conv_pe_quant.sv
// rtl/conv_pe_quant.sv - 3x3 / 1x1 convolution PE with channel-group accumulation and int8 requant
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   valid_in, in_ready     input beat handshake
//   last_channel           beat closes the current output pixel
//   mode_1x1               only the centre tap contributes
//   pixels, weights        CIN_PAR-channel window slice and int8 weights
//   bias, scale, shift     per-pixel requant settings (taken with the last beat)
//   leaky_en               leaky ReLU request (taken with the last beat)
//   out, out_valid         int8 result, held until out_ready
//   out_ready              downstream accepts out
// Macro CONV_PE_LEAKY_EN compiles the leaky stage in conv_requant.
// Stages: S1 products, S2 tap sums, S3 window sum, S4 accumulate, Q1, Q2.
module conv_pe_quant
  import conv_pkg::*;
#(
  parameter int CIN_PAR = 8,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_in,
  output logic                                 in_ready,
  input  logic                                 last_channel,
  input  logic                                 mode_1x1,
  input  logic [0:2][0:2][PIX_W*CIN_PAR-1:0]   pixels,
  input  logic [9*W_W*CIN_PAR-1:0]             weights,
  input  logic signed [ACC_W-1:0]              bias,
  input  logic [SCALE_W-1:0]                   scale,
  input  logic [4:0]                           shift,
  input  logic                                 leaky_en,
  output logic signed [OUT_W-1:0]              out,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int PROD_W = PIX_W + 1 + W_W;
  localparam int TAP_W  = PROD_W + $clog2(CIN_PAR);

  logic en;
  // One enable freezes the whole pipe while a result waits downstream.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  conv_sb_t sb_in, s1_sb, s2_sb, s3_sb, r_sb_d, r_sb;

  logic signed [PROD_W-1:0] prod_d [9][CIN_PAR];
  logic signed [PROD_W-1:0] s1_prod [9][CIN_PAR];
  logic signed [TAP_W-1:0]  tap_d [9];
  logic signed [TAP_W-1:0]  tap_q [9];
  logic [ACC_W-1:0]         cyc_d, cyc_q, acc, raw_q;

  always_comb begin
    sb_in       = '0;
    sb_in.valid = valid_in;
    sb_in.last  = last_channel;
    sb_in.mode  = mode_1x1;
    sb_in.bias  = SB_BIAS_W'(bias);
    sb_in.scale = SB_SCALE_W'(scale);
    sb_in.shift = shift;
    sb_in.leaky = leaky_en;
  end

  // Pixels are unsigned, so they enter the signed multiply with a zero sign bit.
  always_comb begin
    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < CIN_PAR; j++) begin
        if (mode_1x1 && t != 4)
          prod_d[t][j] = '0;
        else
          prod_d[t][j] = PROD_W'($signed({1'b0, pixels[t/3][t%3][j*PIX_W +: PIX_W]}))
                       * PROD_W'($signed(weights[(t*CIN_PAR+j)*W_W +: W_W]));
      end
    end
  end

  always_comb begin
    for (int t = 0; t < 9; t++) begin
      tap_d[t] = '0;
      for (int j = 0; j < CIN_PAR; j++) tap_d[t] = tap_d[t] + TAP_W'(s1_prod[t][j]);
    end
  end

  // Summing directly at ACC_W sign-extends each tap and wraps like the accumulator.
  always_comb begin
    cyc_d = '0;
    for (int t = 0; t < 9; t++) cyc_d = cyc_d + ACC_W'(tap_q[t]);
  end

  always_comb begin
    r_sb_d       = s3_sb;
    r_sb_d.valid = s3_sb.valid && s3_sb.last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sb <= '0;
      s2_sb <= '0;
      s3_sb <= '0;
      cyc_q <= '0;
      for (int t = 0; t < 9; t++) begin
        tap_q[t] <= '0;
        for (int j = 0; j < CIN_PAR; j++) s1_prod[t][j] <= '0;
      end
    end else if (en) begin
      s1_sb   <= sb_in;
      s1_prod <= prod_d;
      s2_sb   <= s1_sb;
      tap_q   <= tap_d;
      s3_sb   <= s2_sb;
      cyc_q   <= cyc_d;
    end
  end

  // The last beat folds in bias and clears acc in the same cycle, so the
  // next pixel's first beat can follow directly behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      raw_q <= '0;
      r_sb  <= '0;
    end else if (en) begin
      r_sb <= r_sb_d;
      if (s3_sb.valid) begin
        if (s3_sb.last) begin
          raw_q <= acc + cyc_q + s3_sb.bias[ACC_W-1:0];
          acc   <= '0;
        end else begin
          acc <= acc + cyc_q;
        end
      end
    end
  end

  logic unused_sb;
  assign unused_sb = ^{s3_sb, r_sb};

  conv_requant #(
    .ACC_W   (ACC_W),
    .SCALE_W (SCALE_W)
  ) u_requant (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (r_sb.valid),
    .raw       (raw_q),
    .scale     (r_sb.scale[SCALE_W-1:0]),
    .shift     (r_sb.shift),
    .leaky_en  (r_sb.leaky),
    .out       (out),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_conv_pe_quant.sv
// tb/tb_conv_pe_quant.sv - self-checking bench for conv_pe_quant
module tb_conv_pe_quant;

  localparam int CIN_PAR = 8;
  localparam int ACC_W   = 32;
  localparam int SCALE_W = 16;
`ifdef CONV_PE_LEAKY_EN
  localparam bit LEAKY_BUILT = 1'b1;
`else
  localparam bit LEAKY_BUILT = 1'b0;
`endif

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             valid_in;
  logic                             in_ready;
  logic                             last_channel;
  logic                             mode_1x1;
  logic [0:2][0:2][8*CIN_PAR-1:0]   pixels;
  logic [72*CIN_PAR-1:0]            weights;
  logic signed [ACC_W-1:0]          bias;
  logic [SCALE_W-1:0]               scale;
  logic [4:0]                       shift;
  logic                             leaky_en;
  logic signed [7:0]                out;
  logic                             out_valid;
  logic                             out_ready;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint model_acc = 0;
  int     exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] pa, wa, pc, wc;
    logic       md;
    int         nb;
    int         bias_v, scale_v, shift_v;
    logic       lk;
    int         exp_out;
  } vec_t;
  vec_t vecs[$];

  conv_pe_quant #(.CIN_PAR(CIN_PAR), .ACC_W(ACC_W), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
    .last_channel(last_channel), .mode_1x1(mode_1x1), .pixels(pixels),
    .weights(weights), .bias(bias), .scale(scale), .shift(shift),
    .leaky_en(leaky_en), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct dot product of the window slice, as plain integers.
  function automatic longint beat_sum();
    longint s = 0;
    for (int t = 0; t < 9; t++) begin
      if (mode_1x1 && t != 4) continue;
      for (int j = 0; j < CIN_PAR; j++)
        s += longint'(pixels[t/3][t%3][j*8 +: 8]) * longint'($signed(weights[(t*CIN_PAR+j)*8 +: 8]));
    end
    return s;
  endfunction

  function automatic int ref_requant(input longint raw, input longint sc, input int sh, input logic lk);
    longint v = raw * sc;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (LEAKY_BUILT && lk && v < 0) v = (v * 13 + 64) >>> 7;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic model_accept();
    longint cyc = beat_sum();
    if (last_channel) begin
      longint raw = longint'(int'(model_acc + cyc + longint'(bias)));
      model_acc = 0;
      exp_q.push_back(ref_requant(raw, longint'(scale), int'(shift), leaky_en));
    end else begin
      model_acc = longint'(int'(model_acc + cyc));
    end
  endtask

  task automatic model_reset();
    model_acc = 0;
    exp_q.delete();
  endtask

  // Every transfer is checked in order against the model's queue.
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", longint'(out_valid), 0);
      else chk("scoreboard_out", longint'(out), longint'(exp_q.pop_front()));
    end
  end

  task automatic set_beat(input logic [7:0] pa, input logic [7:0] wa,
                          input logic [7:0] pc, input logic [7:0] wc, input logic md);
    for (int t = 0; t < 9; t++)
      for (int j = 0; j < CIN_PAR; j++) begin
        pixels[t/3][t%3][j*8 +: 8]     = (t == 4) ? pc : pa;
        weights[(t*CIN_PAR+j)*8 +: 8]  = (t == 4) ? wc : wa;
      end
    mode_1x1 = md;
  endtask

  task automatic rand_beat(input logic md);
    for (int t = 0; t < 9; t++)
      for (int j = 0; j < CIN_PAR; j++) begin
        pixels[t/3][t%3][j*8 +: 8]    = 8'($urandom);
        weights[(t*CIN_PAR+j)*8 +: 8] = 8'($urandom);
      end
    mode_1x1 = md;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic last);
    int guard = 0;
    valid_in = 1'b1;
    last_channel = last;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) chk("accept_timeout", longint'(in_ready), 1);
    @(posedge clk);
    model_accept();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic add_vec(input string name, input logic [7:0] pa, input logic [7:0] wa,
                         input logic [7:0] pc, input logic [7:0] wc, input logic md, input int nb,
                         input int b, input int sc, input int sh, input logic lk, input int e);
    vec_t v;
    v.name = name; v.pa = pa; v.wa = wa; v.pc = pc; v.wc = wc; v.md = md; v.nb = nb;
    v.bias_v = b; v.scale_v = sc; v.shift_v = sh; v.lk = lk; v.exp_out = e;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int rem;
    int guard;
    logic pix_mode;
    logic acc_ok;
    logic signed [7:0] held;

    add_vec("ones_single",  8'd1,   8'd1,    8'd1,  8'd1,    1'b0, 1, 0,  1, 0, 1'b0, 72);
    add_vec("two_beat_sat", 8'd1,   8'd1,    8'd1,  8'd1,    1'b0, 2, 10, 1, 0, 1'b0, 127);
    add_vec("acc_cleared",  8'd1,   8'd1,    8'd1,  8'd1,    1'b0, 1, 0,  1, 0, 1'b0, 72);
    add_vec("neg_leaky",    8'd10,  8'hFF,   8'd10, 8'hFF,   1'b0, 1, 0,  1, 3, 1'b1, LEAKY_BUILT ? -9 : -90);
    add_vec("neg_linear",   8'd10,  8'hFF,   8'd10, 8'hFF,   1'b0, 1, 0,  1, 3, 1'b0, -90);
    add_vec("mode_1x1",     8'd100, 8'd1,    8'd5,  8'd3,    1'b1, 1, 0,  1, 0, 1'b0, 120);
    add_vec("round_shift",  8'd1,   8'd1,    8'd1,  8'd1,    1'b0, 1, 0,  1, 4, 1'b0, 5);
    add_vec("neg_sat",      8'd255, 8'h80,   8'd255, 8'h80,  1'b0, 1, 0,  1, 0, 1'b0, -128);

    rst = 1'b1; valid_in = 1'b0; last_channel = 1'b0; out_ready = 1'b1;
    bias = '0; scale = '0; shift = '0; leaky_en = 1'b0;
    set_beat(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_in_ready",  longint'(in_ready), 1);
    chk("reset_out",       longint'(out), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_beat(vecs[i].pa, vecs[i].wa, vecs[i].pc, vecs[i].wc, vecs[i].md);
      bias = vecs[i].bias_v;
      scale = 16'(vecs[i].scale_v);
      shift = 5'(vecs[i].shift_v);
      leaky_en = vecs[i].lk;
      for (int b = 0; b < vecs[i].nb; b++) send_beat(b == vecs[i].nb - 1);
      wait_out(lat);
      chk({vecs[i].name, "_latency"}, longint'(lat), 6);
      chk({vecs[i].name, "_out"}, longint'(out), longint'(vecs[i].exp_out));
      repeat (2) @(negedge clk);
    end

    // Reset between the first and second beat of a pixel.
    set_beat(8'd200, 8'd100, 8'd200, 8'd100, 1'b0);
    bias = '0; scale = 16'd1; shift = 5'd0; leaky_en = 1'b0;
    send_beat(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midgroup_rst_out_valid", longint'(out_valid), 0);
    chk("midgroup_rst_in_ready", longint'(in_ready), 1);
    set_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    send_beat(1'b1);
    wait_out(lat);
    chk("post_rst_latency", longint'(lat), 6);
    chk("post_rst_out", longint'(out), 72);
    repeat (2) @(negedge clk);

    // Reset while a finished pixel is still in flight.
    send_beat(1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("inflight_flushed", longint'(seen), 0);

    // Stream single-beat pixels and stall the output for four cycles.
    for (int c = 0; c < 12; c++) begin
      rand_beat(1'b0);
      bias = $urandom_range(0, 2000) - 1000;
      scale = 16'd3; shift = 5'd10; leaky_en = 1'($urandom_range(0, 1));
      valid_in = 1'b1; last_channel = 1'b1;
      out_ready = !(c >= 7 && c <= 10);
      #1;
      if (c >= 7 && c <= 10) begin
        chk("stall_out_valid", longint'(out_valid), 1);
        chk("stall_in_ready", longint'(in_ready), 0);
        if (c == 7) held = out;
        else chk("stall_out_hold", longint'(out), longint'(held));
      end
      acc_ok = in_ready;
      @(posedge clk);
      if (acc_ok) model_accept();
      @(negedge clk);
    end
    valid_in = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin @(negedge clk); guard++; end
    chk("stall_drain_pending", longint'(exp_q.size()), 0);

    // Randomised multi-group pixels with random backpressure.
    rem = 0; pix_mode = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (rem == 0) begin
        rem = $urandom_range(1, 3);
        pix_mode = ($urandom_range(0, 3) == 0);
      end
      rand_beat(pix_mode);
      valid_in = ($urandom_range(0, 3) != 0);
      last_channel = (rem == 1);
      bias = $urandom_range(0, 20000) - 10000;
      scale = 16'($urandom_range(0, 300));
      shift = 5'($urandom_range(0, 20));
      leaky_en = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_ok = valid_in && in_ready;
      @(posedge clk);
      if (acc_ok) begin
        model_accept();
        rem--;
      end
      @(negedge clk);
    end
    valid_in = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin @(negedge clk); guard++; end
    chk("random_drain_pending", longint'(exp_q.size()), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
